ram_arbiter: RTL and testbench

Two-port arbiter that shares the single 1024x16 program/data RAM between the CPU (port 0) and the debug/program loader (port 1). Each cycle it grants at most one access, read or write. It drives the RAM's clock enable, write enable, address and write-data lines, and routes the 1-cycle synchronous read data back to the requester that issued the read. It sits between the core/loader and the RAM instance in the top level.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arbiter_if.sv | 29 ++
 rtl/arb_rr2.sv | 20 ++
 rtl/ram_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the program/data RAM arbiter: FSM state encoding,
// port index constants and default geometry.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned P_CPU  = 0;
  localparam int unsigned P_LDR  = 1;

  localparam int unsigned DEF_AW = 10;
  localparam int unsigned DEF_DW = 16;

  // Width of the ownership hold counter (MAX_HOLD is at most 255).
  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bus of one arbiter port. The requester (CPU or loader) uses
// the master modport, the arbiter uses the slave modport.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
) ();

  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin tie-breaker. A lone requester always wins; on a tie the
// port that did not win last time is granted. Grant is one-hot (or zero).
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_winner,
  output logic [1:0] gnt
);

  // Pick the winner from the current requests and the previous winner.
  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_winner ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single 1024x16 program/data RAM between the CPU (port 0) and the
// debug/program loader (port 1). At most one access is granted per cycle;
// read data returns one cycle later, tagged to the port that issued it.
// Optional build macro ARB_STATS_EN adds per-port read/write counters and a
// contention counter.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  ram_arbiter_if.slave  p0,
  ram_arbiter_if.slave  p1,
  output logic          o_ram_ce,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_w_addr,
  output logic [AW-1:0] o_ram_r_addr,
  output logic [DW-1:0] o_ram_w_data,
  input  logic [DW-1:0] i_ram_r_data
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   o_stat_rd0,
  output logic [15:0]   o_stat_wr0,
  output logic [15:0]   o_stat_rd1,
  output logic [15:0]   o_stat_wr1,
  output logic [15:0]   o_stat_conflict
`endif
);

  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [1:0]        req, we, lock;
  logic [1:0]        rr_gnt, gnt;
  logic              own_active, own_idx, win;
  logic [HOLD_W-1:0] cnt_inc;

  logic [1:0]        rv_q;
  logic [DW-1:0]     rdata0_q, rdata1_q;

  assign req[P_CPU]  = p0.req;
  assign req[P_LDR]  = p1.req;
  assign we[P_CPU]   = p0.we;
  assign we[P_LDR]   = p1.we;
  assign lock[P_CPU] = p0.lock;
  assign lock[P_LDR] = p1.lock;

  arb_rr2 u_rr (
    .req         (req),
    .last_winner (last_q),
    .gnt         (rr_gnt)
  );

  // Grant decision and next-state computation. The entry grant into OWNx
  // already counts towards hold_cnt, so MAX_HOLD bounds the whole run of
  // consecutive grants the other port has to wait through.
  always_comb begin
    gnt        = '0;
    state_d    = state_q;
    last_d     = last_q;
    hold_d     = hold_q;
    win        = 1'b0;
    cnt_inc    = hold_q;
    own_idx    = (state_q == OWN1);
    own_active = ((state_q == OWN0) && req[P_CPU]) ||
                 ((state_q == OWN1) && req[P_LDR]);
    if (!i_rst) begin
      if (own_active) begin
        gnt     = own_idx ? 2'b10 : 2'b01;
        last_d  = own_idx;
        cnt_inc = (hold_q == '1) ? hold_q
                                 : hold_q + {{(HOLD_W-1){1'b0}}, req[~own_idx]};
        if (!lock[own_idx] || (cnt_inc >= MAX_HOLD_C)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = cnt_inc;
        end
      end else begin
        gnt = rr_gnt;
        if (state_q != IDLE) begin
          state_d = IDLE;
          hold_d  = '0;
        end
        if (|rr_gnt) begin
          win    = rr_gnt[1];
          last_d = win;
          if (lock[win] &&
              ({{(HOLD_W-1){1'b0}}, req[~win]} < MAX_HOLD_C)) begin
            state_d = win ? OWN1 : OWN0;
            hold_d  = {{(HOLD_W-1){1'b0}}, req[~win]};
          end
        end
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign p0.gnt       = gnt[P_CPU];
  assign p1.gnt       = gnt[P_LDR];
  assign o_ram_ce     = |gnt;
  assign o_ram_we     = |(gnt & we);
  assign o_ram_w_addr = gnt[P_LDR] ? p1.addr  : p0.addr;
  assign o_ram_r_addr = gnt[P_LDR] ? p1.addr  : p0.addr;
  assign o_ram_w_data = gnt[P_LDR] ? p1.wdata : p0.wdata;

  // Read tag pipeline and per-port hold of the last returned data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rv_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rv_q <= gnt & ~we;
      if (rv_q[P_CPU]) rdata0_q <= i_ram_r_data;
      if (rv_q[P_LDR]) rdata1_q <= i_ram_r_data;
    end
  end

  // Gating with i_rst drops a tag that was registered just before reset.
  assign p0.rvalid = rv_q[P_CPU] & ~i_rst;
  assign p1.rvalid = rv_q[P_LDR] & ~i_rst;
  assign p0.rdata  = p0.rvalid ? i_ram_r_data : rdata0_q;
  assign p1.rdata  = p1.rvalid ? i_ram_r_data : rdata1_q;

`ifdef ARB_STATS_EN
  // Access and contention statistics; all counters wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_rd0      <= '0;
      o_stat_wr0      <= '0;
      o_stat_rd1      <= '0;
      o_stat_wr1      <= '0;
      o_stat_conflict <= '0;
    end else begin
      if (gnt[P_CPU] && !we[P_CPU]) o_stat_rd0 <= o_stat_rd0 + 16'd1;
      if (gnt[P_CPU] &&  we[P_CPU]) o_stat_wr0 <= o_stat_wr0 + 16'd1;
      if (gnt[P_LDR] && !we[P_LDR]) o_stat_rd1 <= o_stat_rd1 + 16'd1;
      if (gnt[P_LDR] &&  we[P_LDR]) o_stat_wr1 <= o_stat_wr1 + 16'd1;
      if ((&req) && (|gnt))         o_stat_conflict <= o_stat_conflict + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: grant checks inline per scenario task,
// read data checked through a scoreboard queue against a shadow memory.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic        clk;
  logic        rst;
  logic        ram_ce, ram_we;
  logic [9:0]  ram_w_addr, ram_r_addr;
  logic [15:0] ram_w_data, ram_rdata;
`ifdef ARB_STATS_EN
  logic [15:0] st_rd0, st_wr0, st_rd1, st_wr1, st_conf;
`endif

  ram_arbiter_if #(.AW(10), .DW(16)) bus0 ();
  ram_arbiter_if #(.AW(10), .DW(16)) bus1 ();

  ram_arbiter #(.AW(10), .DW(16), .MAX_HOLD(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .p0           (bus0),
    .p1           (bus1),
    .o_ram_ce     (ram_ce),
    .o_ram_we     (ram_we),
    .o_ram_w_addr (ram_w_addr),
    .o_ram_r_addr (ram_r_addr),
    .o_ram_w_data (ram_w_data),
    .i_ram_r_data (ram_rdata)
`ifdef ARB_STATS_EN
    ,
    .o_stat_rd0      (st_rd0),
    .o_stat_wr0      (st_wr0),
    .o_stat_rd1      (st_rd1),
    .o_stat_wr1      (st_wr1),
    .o_stat_conflict (st_conf)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] shadow [int];

  function automatic logic [15:0] pat(input logic [9:0] a);
    return {6'h2B, a} ^ 16'h0F0F;
  endfunction

  function automatic logic [15:0] exp_mem(input logic [9:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return pat(a);
  endfunction

  // RAM model: synchronous write, registered read.
  logic [15:0] ram_mem [1024];
  bit          ram_wr  [1024];
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      ram_mem[ram_w_addr] <= ram_w_data;
      ram_wr[ram_w_addr]  <= 1'b1;
    end
    if (ram_ce && !ram_we)
      ram_rdata <= ram_wr[ram_r_addr] ? ram_mem[ram_r_addr] : pat(ram_r_addr);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every cycle, rvalid of both ports must match the entry due now.
  always @(negedge clk) begin
    bit          e0, e1;
    logic [15:0] ed;
    exp_t        e;
    e0 = 1'b0;
    e1 = 1'b0;
    ed = '0;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL sb_stale port=%0d due=%0d now=%0d", e.port, e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      e0 = (e.port == 0);
      e1 = (e.port == 1);
      ed = e.data;
    end
    checks++;
    if (bus0.rvalid !== e0) begin
      errors++;
      $display("FAIL rvalid0 cyc=%0d got=%b exp=%b", cyc, bus0.rvalid, e0);
    end
    checks++;
    if (bus1.rvalid !== e1) begin
      errors++;
      $display("FAIL rvalid1 cyc=%0d got=%b exp=%b", cyc, bus1.rvalid, e1);
    end
    if (e0) begin
      checks++;
      if (bus0.rdata !== ed) begin
        errors++;
        $display("FAIL rdata0 cyc=%0d got=%h exp=%h", cyc, bus0.rdata, ed);
      end
    end
    if (e1) begin
      checks++;
      if (bus1.rdata !== ed) begin
        errors++;
        $display("FAIL rdata1 cyc=%0d got=%h exp=%h", cyc, bus1.rdata, ed);
      end
    end
  end

  task automatic drive(input logic rs,
                       input logic r0, w0, l0, input logic [9:0] a0, input logic [15:0] d0,
                       input logic r1, w1, l1, input logic [9:0] a1, input logic [15:0] d1);
    @(posedge clk);
    #1;
    rst        = rs;
    bus0.req   = r0; bus0.we = w0; bus0.lock = l0; bus0.addr = a0; bus0.wdata = d0;
    bus1.req   = r1; bus1.we = w1; bus1.lock = l1; bus1.addr = a1; bus1.wdata = d1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 10'h001, '0, 1, 0, 0, 10'h002, '0);
      @(negedge clk);
      checks++;
      if ({bus0.gnt, bus1.gnt, ram_ce} !== 3'b000) begin
        errors++;
        $display("FAIL rst_gate got=%b exp=000", {bus0.gnt, bus1.gnt, ram_ce});
      end
    end
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus0.rdata, bus1.rdata} !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got=%h exp=0", {bus0.rdata, bus1.rdata});
    end
    checks++;
    if (ram_ce !== 1'b0) begin
      errors++;
      $display("FAIL idle_ce got=%b exp=0", ram_ce);
    end
  endtask

  task automatic test_read0();
    drive(0, 1, 0, 0, 10'h005, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus0.gnt, bus1.gnt, ram_ce, ram_we} !== 4'b1010) begin
      errors++;
      $display("FAIL read0_gnt got=%b exp=1010", {bus0.gnt, bus1.gnt, ram_ce, ram_we});
    end
    checks++;
    if (ram_r_addr !== 10'h005) begin
      errors++;
      $display("FAIL read0_addr got=%h exp=005", ram_r_addr);
    end
    sb.push_back('{0, exp_mem(10'h005), cyc + 1});
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_write_read1();
    drive(0, 0, 0, 0, '0, '0, 1, 1, 0, 10'h3FF, 16'hBEEF);
    @(negedge clk);
    checks++;
    if ({bus0.gnt, bus1.gnt, ram_ce, ram_we} !== 4'b0111) begin
      errors++;
      $display("FAIL wr1_gnt got=%b exp=0111", {bus0.gnt, bus1.gnt, ram_ce, ram_we});
    end
    checks++;
    if ({ram_w_addr, ram_w_data} !== {10'h3FF, 16'hBEEF}) begin
      errors++;
      $display("FAIL wr1_bus got=%h/%h exp=3ff/beef", ram_w_addr, ram_w_data);
    end
    shadow[int'(10'h3FF)] = 16'hBEEF;
    drive(0, 0, 0, 0, '0, '0, 1, 0, 0, 10'h3FF, '0);
    @(negedge clk);
    checks++;
    if ({bus0.gnt, bus1.gnt, ram_we, ram_r_addr} !== {3'b010, 10'h3FF}) begin
      errors++;
      $display("FAIL rd1_gnt got=%b/%h exp=010/3ff", {bus0.gnt, bus1.gnt, ram_we}, ram_r_addr);
    end
    sb.push_back('{1, exp_mem(10'h3FF), cyc + 1});
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_alternate();
    logic [9:0] a0, a1;
    bit         w0;
    a0 = 10'h010;
    a1 = 10'h200;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 0, a0, '0, 1, 0, 0, a1, '0);
      @(negedge clk);
      w0 = ((i % 2) == 0);
      checks++;
      if ({bus0.gnt, bus1.gnt} !== {w0, !w0}) begin
        errors++;
        $display("FAIL alt_gnt i=%0d got=%b exp=%b", i, {bus0.gnt, bus1.gnt}, {w0, !w0});
      end
      if (w0) begin
        sb.push_back('{0, exp_mem(a0), cyc + 1});
        a0 = a0 + 10'd1;
      end else begin
        sb.push_back('{1, exp_mem(a1), cyc + 1});
        a1 = a1 + 10'd1;
      end
    end
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_lock_max();
    logic [9:0] a0, a1;
    bit         w0;
    drive(0, 1, 0, 0, 10'h050, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if ({bus0.gnt, bus1.gnt} !== 2'b10) begin
      errors++;
      $display("FAIL lock_pre got=%b exp=10", {bus0.gnt, bus1.gnt});
    end
    sb.push_back('{0, exp_mem(10'h050), cyc + 1});
    a0 = 10'h060;
    a1 = 10'h100;
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 0, 0, a0, '0, 1, 0, 1, a1, '0);
      @(negedge clk);
      w0 = (k == 8);
      checks++;
      if ({bus0.gnt, bus1.gnt} !== {w0, !w0}) begin
        errors++;
        $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, {bus0.gnt, bus1.gnt}, {w0, !w0});
      end
      if (w0) begin
        sb.push_back('{0, exp_mem(a0), cyc + 1});
        a0 = a0 + 10'd1;
      end else begin
        sb.push_back('{1, exp_mem(a1), cyc + 1});
        a1 = a1 + 10'd1;
      end
    end
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset_midread();
    drive(0, 1, 0, 0, 10'h007, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus0.gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt got=%b exp=1", bus0.gnt);
    end
    drive(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if (bus0.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rvalid got=%b exp=0", bus0.rvalid);
    end
    drive(0, 1, 0, 0, 10'h008, '0, 1, 0, 0, 10'h009, '0);
    @(negedge clk);
    checks++;
    if ({bus0.gnt, bus1.gnt} !== 2'b10) begin
      errors++;
      $display("FAIL post_rst_tie got=%b exp=10", {bus0.gnt, bus1.gnt});
    end
    sb.push_back('{0, exp_mem(10'h008), cyc + 1});
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    logic [9:0] a0, a1;
    drive(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 10'(10'h020 + i), '0, 0, 0, 0, '0, '0);
      @(negedge clk);
      sb.push_back('{0, exp_mem(10'(10'h020 + i)), cyc + 1});
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, '0, '0, 1, 1, 0, 10'(10'h280 + i), 16'(16'h1200 + i));
      @(negedge clk);
      shadow[int'(10'h280) + i] = 16'(16'h1200 + i);
    end
    a0 = 10'h300;
    a1 = 10'h280;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 0, a0, 16'(16'hA000 + i), 1, 0, 0, a1, '0);
      @(negedge clk);
      if ((i % 2) == 0) begin
        shadow[int'(a0)] = 16'(16'hA000 + i);
        a0 = a0 + 10'd1;
      end else begin
        sb.push_back('{1, exp_mem(a1), cyc + 1});
        a1 = a1 + 10'd1;
      end
    end
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if ({st_rd0, st_wr0, st_rd1, st_wr1, st_conf} !== {16'd3, 16'd2, 16'd2, 16'd2, 16'd4}) begin
      errors++;
      $display("FAIL stats got=rd0 %0d wr0 %0d rd1 %0d wr1 %0d conf %0d exp=3 2 2 2 4",
               st_rd0, st_wr0, st_rd1, st_wr1, st_conf);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.lock = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.we = 1'b0; bus1.lock = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    test_reset();
    test_read0();
    test_write_read1();
    test_alternate();
    test_lock_max();
    test_reset_midread();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    drive(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
